div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the Nbit_ALU in the EX stage. It consumes the forwarded rs1/rs2 operands and funct3 from ID/EX, and feeds the EX/MEM ALU-result path.
- It raises a stall so the PC, IF/ID and ID/EX registers hold until the quotient or remainder is ready.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  ID_EX holds a valid divide-class instruction (opcode 01100, bit25=1, funct3[2]=1).
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  WIDTH  forwarded rs1 value.
- divisor  in  WIDTH  forwarded rs2 value.
- flush  in  1  branch/jump/halt squash of the EX instruction.
- busy  out  1  high while the FSM is not in IDLE.
- stall  out  1  combinational hold request to the pipeline.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - busy=0, done=0, result=0.
  - counter and internal registers cleared.
  - Reset overrides all other inputs, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start (edge 0), latch op.
  - For signed ops, latch |dividend| and |divisor| plus the two sign bits.
  - If divisor==0, or op==DIV with dividend==0x80..0 and divisor==all-ones: go straight to DONE with the special result loaded.
  - Otherwise go to CALC with counter=WIDTH, remainder register=0, quotient register=|dividend|.
- CALC:
  - One iteration per cycle: shift {rem,quo} left 1, trial-subtract |divisor|.
  - If the difference is non-negative, keep it and set quo[0]=1.
  - Decrement counter; when counter reaches 1 on this edge, go to FIX.
- FIX:
  - Signed quotient negated iff the two sign bits differ.
  - Signed remainder takes the dividend's sign.
  - Load result, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - A start sampled in DONE is accepted as a new operation (back-to-back).
- Latency, with start sampled at edge 0:
  - done is high in cycle WIDTH+2 (34 by default) for the normal path.
  - done is high in cycle 1 for special cases.
- Special results:
  - Divide by zero: quotient=all-ones, remainder=dividend.
  - Signed overflow: quotient=0x80000000, remainder=0.
- result holds its value after DONE until the next result load.
- stall = (start & state==IDLE) | state==CALC | state==FIX. It is low in the DONE cycle so the pipeline advances with result.
- start is ignored in CALC and FIX.
- flush has priority over start in every state except under reset:
  - Next state is IDLE, with no done pulse.
  - result is unchanged.
  - A flush in the DONE cycle suppresses nothing, because done is already asserted.
- busy = (state != IDLE).

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- When defined:
  - Registers hold the last completed {dividend, divisor, signedness, quotient, remainder} plus a valid bit.
  - A start in IDLE whose operands and signedness match a valid entry goes directly to DONE with the cached quotient or remainder; done fires in cycle 1. This covers DIV followed by REM on the same operands.
  - The valid bit is cleared by reset and by flush during CALC/FIX.
- When undefined: no cache registers; every non-special operation takes WIDTH+2 cycles.

Decomposition:
- Package rv_div_pkg holds:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU;
  - state enum IDLE/CALC/FIX/DONE;
  - constant DIV_LATENCY=WIDTH+2.
- One natural sub-module: div_step, a combinational single restoring iteration. It takes {rem, quo, divisor} and returns the next {rem, quo}. It is instantiated once in CALC.

Test Plan:
- DIVU 100/7 -> stall high in cycles 0..33, done in cycle 34, result=14. REMU with the same operands -> result=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> result=0xFFFFFFFD. REM -7/2 -> result=0xFFFFFFFF.
- DIVU 5/0 -> done in cycle 1, result=0xFFFFFFFF. REM 5/0 -> result=5.
- DIV 0x80000000 / 0xFFFFFFFF -> done in cycle 1, result=0x80000000. REM with the same operands -> result=0.
- Flush:
  - DIVU 1000/3 with flush asserted in cycle 10 -> no done pulse, busy=0 from cycle 11, result retains its prior value.
  - A new start in cycle 11 completes normally with result=333.
- Reset and cache:
  - reset=0 in cycle 20 of an operation -> next cycle busy=0, done=0, result=0.
  - With DIV_RESULT_CACHE_EN: DIVU 100/7, then REMU 100/7 -> second result=2 with done in cycle 1.

Source files
------------

// File: rtl/rv_div_pkg.sv
// Shared definitions for the RV32M iterative divider: op encodings, FSM states
// and the normal-path latency.
package rv_div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    // funct3[1:0] of the divide-class instructions
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic           neg;

    always_comb begin
        // One extra bit: the shifted partial remainder can reach 2*divisor-1.
        shifted  = {rem, quo[WIDTH-1]};
        neg      = shifted < {1'b0, divisor};
        rem_next = neg ? shifted[WIDTH-1:0] : WIDTH'(shifted - {1'b0, divisor});
        quo_next = {quo[WIDTH-2:0], ~neg};
    end

endmodule

// File: rtl/div_unit.sv
// EX-stage iterative divider for DIV/DIVU/REM/REMU; stalls the front of the
// pipeline while iterating. Optional last-result cache: DIV_RESULT_CACHE_EN.
module div_unit
    import rv_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    div_state_e       state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic             sign_a_q, sign_b_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
    logic [WIDTH-1:0] rem_step, quo_step, q_fix, r_fix;
    logic [WIDTH-1:0] abs_a, abs_b, special_val, fast_val;
    logic             in_signed, in_sign_a, in_sign_b;
    logic             launch, special, fast_hit;

    always_comb begin
        in_signed   = ~op[0];
        in_sign_a   = in_signed & dividend[WIDTH-1];
        in_sign_b   = in_signed & divisor[WIDTH-1];
        abs_a       = in_sign_a ? -dividend : dividend;
        abs_b       = in_sign_b ? -divisor : divisor;
        special     = (divisor == '0) ||
                      (op == DIV_OP_DIV && dividend == MIN_NEG && divisor == ALL_ONES);
        if (divisor == '0) special_val = op[1] ? dividend : ALL_ONES;
        else               special_val = op[1] ? '0 : MIN_NEG;
        q_fix       = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        r_fix       = sign_a_q ? -rem_q : rem_q;
        launch      = start & ~flush & (state == IDLE || state == DONE);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic             c_valid, c_signed;
    logic [WIDTH-1:0] c_a, c_b, c_quo, c_rem, a_q, b_q;

    assign fast_hit = c_valid && c_a == dividend && c_b == divisor && c_signed == in_signed;
    assign fast_val = op[1] ? c_rem : c_quo;

    // Both quotient and remainder are captured so DIV then REM hits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            c_valid  <= 1'b0;
            c_signed <= 1'b0;
            c_a      <= '0;
            c_b      <= '0;
            c_quo    <= '0;
            c_rem    <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            if (launch) begin
                a_q <= dividend;
                b_q <= divisor;
            end
            if (state == FIX && !flush) begin
                c_valid  <= 1'b1;
                c_signed <= ~op_q[0];
                c_a      <= a_q;
                c_b      <= b_q;
                c_quo    <= q_fix;
                c_rem    <= r_fix;
            end else if (flush && (state == CALC || state == FIX)) begin
                c_valid <= 1'b0;
            end
        end
    end
`else
    assign fast_hit = 1'b0;
    assign fast_val = '0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: begin
                if (flush)      state_d = IDLE;
                else if (start) state_d = (special || fast_hit) ? DONE : CALC;
                else            state_d = IDLE;
            end
            CALC:    state_d = flush ? IDLE : ((cnt == CNT_W'(1)) ? FIX : CALC);
            FIX:     state_d = flush ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_d;
            if (launch) begin
                op_q     <= op;
                sign_a_q <= in_sign_a;
                sign_b_q <= in_sign_b;
                dvs_q    <= abs_b;
                rem_q    <= '0;
                quo_q    <= abs_a;
                cnt      <= CNT_W'(WIDTH);
                if (special)       result_q <= special_val;
                else if (fast_hit) result_q <= fast_val;
            end else if (state == CALC && !flush) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt   <= cnt - CNT_W'(1);
            end else if (state == FIX && !flush) begin
                result_q <= op_q[1] ? r_fix : q_fix;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    // Low in DONE so the pipeline advances together with the result.
    assign stall     = (start && state == IDLE) || state == CALC || state == FIX;
    assign result    = result_q;
    assign dbg_state = state;

endmodule
